// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one memory port between two request/ack masters.
// Define MEM_ARB_TIMEOUT_EN to add a WAIT timeout with a sticky err output.
module mem_port_arbiter #(
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_w,
  output logic              mem_start,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_readrdy,
  input  logic              mem_saverdy,
`ifdef MEM_ARB_TIMEOUT_EN
  output logic              err,
`endif
  output logic              busy,
  output logic              gnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic              ptr_reg;
  logic              gnt_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              early_reg;
  logic [DATA_W-1:0] early_data_reg;

  logic [1:0]        req_vec;
  logic [1:0]        we_vec;
  logic [ADDR_W-1:0] addr_arr  [2];
  logic [DATA_W-1:0] wdata_arr [2];
  logic [DATA_W-1:0] rdata_arr [2];
  logic [1:0]        ack_vec;

  logic              grant_valid;
  logic              grant_sel;
  logic              complete;
  logic              finish;
  logic [DATA_W-1:0] result_next;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  assign req_vec      = {req1, req0};
  assign we_vec       = {we1, we0};
  assign addr_arr[0]  = addr0;
  assign addr_arr[1]  = addr1;
  assign wdata_arr[0] = wdata0;
  assign wdata_arr[1] = wdata1;

  // Contention goes to the pointer; otherwise whichever single port is asking.
  assign grant_valid = |req_vec;
  assign grant_sel   = (req0 && req1) ? ptr_reg : req1;
  assign complete    = we_reg ? mem_saverdy : mem_readrdy;
  assign finish      = (state_reg == WAIT) && (state_next == ACK);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_reg;
  logic             err_reg;
  logic             timeout_hit;

  assign timeout_hit = (state_reg == WAIT) && !early_reg && !complete &&
                       (cnt_reg == CNT_W'(TIMEOUT - 1));
  assign err         = err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      cnt_reg <= (state_reg == WAIT) ? cnt_reg + CNT_W'(1) : '0;
      if (timeout_hit) begin
        err_reg <= 1'b1;
      end
    end
  end
`endif

  always_comb begin
    state_next  = state_reg;
    result_next = '0;
    case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (early_reg) begin
          state_next  = ACK;
          result_next = early_data_reg;
        end else if (complete) begin
          state_next  = ACK;
          result_next = we_reg ? '0 : mem_rdata;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          state_next = ACK;
        end
`endif
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      ptr_reg        <= 1'b0;
      gnt_reg        <= 1'b0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      early_reg      <= 1'b0;
      early_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            gnt_reg   <= grant_sel;
            we_reg    <= we_vec[grant_sel];
            addr_reg  <= addr_arr[grant_sel];
            wdata_reg <= wdata_arr[grant_sel];
          end
          early_reg <= 1'b0;
        end
        // A completion arriving alongside the strobe is remembered for WAIT.
        ISSUE: begin
          early_reg      <= complete;
          early_data_reg <= we_reg ? '0 : mem_rdata;
        end
        ACK: begin
          ptr_reg   <= ~gnt_reg;
          early_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign ack_vec[gi] = (state_reg == ACK) && (gnt_reg == 1'(gi));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rdata_arr[gi] <= '0;
      end else if (finish && (gnt_reg == 1'(gi))) begin
        rdata_arr[gi] <= result_next;
      end
    end
  end

  assign ack0      = ack_vec[0];
  assign ack1      = ack_vec[1];
  assign rdata0    = rdata_arr[0];
  assign rdata1    = rdata_arr[1];
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign mem_start = (state_reg == ISSUE) && !we_reg;
  assign mem_w     = (state_reg == ISSUE) && we_reg;
  assign busy      = (state_reg != IDLE);
  assign gnt       = gnt_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a latency-programmable memory model answers
// strobes, expected transactions are queued at request time and retired on ack.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [14:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1;
  logic [14:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_w, mem_start;
  logic [31:0] mem_rdata;
  logic        mem_readrdy, mem_saverdy;
  logic        busy, gnt;
`ifdef MEM_ARB_TIMEOUT_EN
  logic        err;
`endif

  mem_port_arbiter #(.ADDR_W(15), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_w(mem_w), .mem_start(mem_start),
    .mem_rdata(mem_rdata), .mem_readrdy(mem_readrdy), .mem_saverdy(mem_saverdy),
`ifdef MEM_ARB_TIMEOUT_EN
    .err(err),
`endif
    .busy(busy), .gnt(gnt)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int          port;
    logic        we;
    logic [14:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          diff;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int strobe_cyc = 0;
  int entry_strobes = 0;
  bit allow_stray = 1'b0;

  // memory model controls
  int          mem_lat = 3;
  int          wrong_lat = 0;
  int          cnt = 0;
  int          wrong_cnt = 0;
  logic        pend_we = 1'b0;
  logic [31:0] pend_data = '0;
  bit          rd_ovr_en = 1'b0;
  logic [31:0] rd_ovr = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [14:0] a);
    return {a, 17'h0} ^ 32'h5A5A_1234 ^ {17'h0, a};
  endfunction

  function automatic int lat_diff(input int lat);
    return (lat == 0) ? 2 : lat + 1;
  endfunction

  task automatic push_exp(input int port, input logic we, input logic [14:0] addr,
                          input logic [31:0] wdata, input int diff, input logic [31:0] rdata);
    exp_t e;
    e.port = port; e.we = we; e.addr = addr; e.wdata = wdata; e.diff = diff;
    e.rdata = we ? 32'h0 : rdata;
    sb.push_back(e);
  endtask

  task automatic do_req(input int p, input logic w, input logic [14:0] a, input logic [31:0] d);
    bit got;
    got = 1'b0;
    @(negedge clk);
    if (p == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      got = (p == 0) ? ack0 : ack1;
    end
    check_eq($sformatf("ack_seen_p%0d", p), got, 1'b1);
    @(posedge clk);
    #1;
    if (p == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model: answers each strobe with the proper rdy after mem_lat cycles.
  initial begin
    mem_readrdy = 1'b0;
    mem_saverdy = 1'b0;
    mem_rdata   = 32'h0BAD_F00D;
    forever begin
      @(negedge clk);
      mem_readrdy = 1'b0;
      mem_saverdy = 1'b0;
      mem_rdata   = 32'h0BAD_F00D;
      if (wrong_cnt > 0) begin
        wrong_cnt--;
        if (wrong_cnt == 0) begin
          if (pend_we) mem_readrdy = 1'b1;
          else         mem_saverdy = 1'b1;
        end
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          if (pend_we) mem_saverdy = 1'b1;
          else begin mem_readrdy = 1'b1; mem_rdata = pend_data; end
        end
      end
      if (mem_start || mem_w) begin
        pend_we   = mem_w;
        pend_data = rd_ovr_en ? rd_ovr : mem_fn(mem_addr);
        if (mem_lat == 0) begin
          if (pend_we) mem_saverdy = 1'b1;
          else begin mem_readrdy = 1'b1; mem_rdata = pend_data; end
        end else begin
          cnt = mem_lat;
        end
        if (wrong_lat > 0) wrong_cnt = wrong_lat;
      end
    end
  end

  // Monitor: checks strobes against the scoreboard head and retires entries on ack.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (mem_start || mem_w) begin
      if (sb.size() > 0) begin
        check_eq("strobe_is_write", mem_w, sb[0].we);
        check_eq("strobe_exclusive", mem_start & mem_w, 1'b0);
        check_eq("strobe_addr", mem_addr, sb[0].addr);
        if (sb[0].we) check_eq("strobe_wdata", mem_wdata, sb[0].wdata);
        check_eq("strobe_gnt", gnt, sb[0].port[0]);
        check_eq("busy_in_issue", busy, 1'b1);
        strobe_cyc = cyc;
        entry_strobes++;
      end else if (!allow_stray) begin
        check_eq("stray_strobe", mem_start | mem_w, 1'b0);
      end
    end
    if (ack0 || ack1) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_eq("ack_exclusive", ack0 & ack1, 1'b0);
        check_eq("ack_port", ack1, e.port[0]);
        check_eq("ack_rdata", (e.port == 1) ? rdata1 : rdata0, e.rdata);
        check_eq("ack_latency", cyc - strobe_cyc, e.diff);
        check_eq("ack_strobes", entry_strobes, 1);
        check_eq("ack_addr_hold", mem_addr, e.addr);
        if (e.we) check_eq("ack_wdata_hold", mem_wdata, e.wdata);
        entry_strobes = 0;
        $display("txn port=%0d we=%0d addr=0x%04h wdata=0x%08h rdata=0x%08h lat=%0d",
                 e.port, e.we, e.addr, e.wdata, (e.port == 1) ? rdata1 : rdata0,
                 cyc - strobe_cyc);
      end else begin
        check_eq("stray_ack", ack0 | ack1, 1'b0);
      end
    end
  end

  initial begin
    bit seen;
    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_acks", {ack1, ack0}, 2'b00);
    check_eq("rst_strobes", {mem_w, mem_start}, 2'b00);
    check_eq("rst_gnt", gnt, 1'b0);
    check_eq("rst_mem_addr", mem_addr, 15'h0);
    check_eq("rst_rdata0", rdata0, 32'h0);
    rst = 1'b0;

    // single read on port 0
    rd_ovr_en = 1'b1; rd_ovr = 32'hDEAD_BEEF; mem_lat = 3;
    push_exp(0, 1'b0, 15'h0123, 32'h0, lat_diff(3), 32'hDEAD_BEEF);
    do_req(0, 1'b0, 15'h0123, 32'h0);
    rd_ovr_en = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rdata0_hold", rdata0, 32'hDEAD_BEEF);

    // write on port 1
    mem_lat = 1;
    push_exp(1, 1'b1, 15'h0800, 32'h1234_5678, lat_diff(1), 32'h0);
    do_req(1, 1'b1, 15'h0800, 32'h1234_5678);
    repeat (2) @(negedge clk);
    check_eq("rdata1_write_zero", rdata1, 32'h0);
    check_eq("rdata0_still_held", rdata0, 32'hDEAD_BEEF);

    // both held: order p0, p1, p0, p1
    mem_lat = 2;
    push_exp(0, 1'b0, 15'h0010, 32'h0,         lat_diff(2), mem_fn(15'h0010));
    push_exp(1, 1'b1, 15'h0020, 32'hCAFE_0020, lat_diff(2), 32'h0);
    push_exp(0, 1'b1, 15'h0030, 32'hCAFE_0030, lat_diff(2), 32'h0);
    push_exp(1, 1'b0, 15'h0040, 32'h0,         lat_diff(2), mem_fn(15'h0040));
    fork
      begin do_req(0, 1'b0, 15'h0010, 32'h0); do_req(0, 1'b1, 15'h0030, 32'hCAFE_0030); end
      begin do_req(1, 1'b1, 15'h0020, 32'hCAFE_0020); do_req(1, 1'b0, 15'h0040, 32'h0); end
    join

    // rdy already present during the strobe cycle
    mem_lat = 0;
    push_exp(1, 1'b0, 15'h0077, 32'h0, lat_diff(0), mem_fn(15'h0077));
    do_req(1, 1'b0, 15'h0077, 32'h0);

    // wrong-type completion ignored, real one 5 cycles later
    mem_lat = 7; wrong_lat = 2;
    push_exp(0, 1'b0, 15'h0100, 32'h0, lat_diff(7), mem_fn(15'h0100));
    do_req(0, 1'b0, 15'h0100, 32'h0);
    wrong_lat = 0;

    // reset in WAIT aborts the read (pointer is at port 1 here)
    allow_stray = 1'b1; mem_lat = 20;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 15'h0055;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = mem_start;
    end
    check_eq("abort_strobe_seen", seen, 1'b1);
    repeat (2) @(negedge clk);
    check_eq("abort_busy_wait", busy, 1'b1);
    #1 rst = 1'b1;
    #1;
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_acks", {ack1, ack0}, 2'b00);
    check_eq("abort_strobes", {mem_w, mem_start}, 2'b00);
    req0 = 1'b0; cnt = 0; wrong_cnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    allow_stray = 1'b0;

    // pointer back at port 0 after reset
    mem_lat = 2;
    push_exp(0, 1'b0, 15'h0200, 32'h0,         lat_diff(2), mem_fn(15'h0200));
    push_exp(1, 1'b1, 15'h0300, 32'h7777_0300, lat_diff(2), 32'h0);
    fork
      do_req(0, 1'b0, 15'h0200, 32'h0);
      do_req(1, 1'b1, 15'h0300, 32'h7777_0300);
    join

`ifdef MEM_ARB_TIMEOUT_EN
    // no rdy at all: forced ack with zero data and sticky err
    mem_lat = 1000;
    push_exp(0, 1'b0, 15'h0444, 32'h0, TMO + 1, 32'h0);
    do_req(0, 1'b0, 15'h0444, 32'h0);
    cnt = 0;
    check_eq("err_set", err, 1'b1);
    repeat (5) @(negedge clk);
    check_eq("err_sticky", err, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("err_cleared", err, 1'b0);
    rst = 1'b0;
`endif

    repeat (3) @(negedge clk);
    check_eq("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d expected=finish", cyc);
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 32-bit program/data memory port (15-bit word address, start-read/write strobes, readrdy/saverdy completion) between two requesters.
- Port 0 is the CPU memory controller; port 1 is an auxiliary master such as a loader or DMA.
- Round-robin grant, one transaction at a time, request/ack handshake on each side.
- Sits between the CPU top level and the memory router that selects RAM or ROM.

Parameters:
- ADDR_W, 15: memory word address width.
- DATA_W, 32: memory data width.
- TIMEOUT, 255: cycles in WAIT before abort (used only with the optional feature).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset.
- req0  input  1  port 0 request; held until ack0.
- we0  input  1  port 0 write enable (1 = write, 0 = read).
- addr0  input  ADDR_W  port 0 address.
- wdata0  input  DATA_W  port 0 write data.
- ack0  output  1  port 0 completion pulse.
- rdata0  output  DATA_W  port 0 read data, valid while ack0 is high.
- req1, we1, addr1, wdata1, ack1, rdata1: identical set for port 1.
- mem_addr  output  ADDR_W  address to memory.
- mem_wdata  output  DATA_W  write data to memory.
- mem_w  output  1  write strobe, 1-cycle pulse.
- mem_start  output  1  read-start strobe, 1-cycle pulse.
- mem_rdata  input  DATA_W  read data from memory.
- mem_readrdy  input  1  read complete.
- mem_saverdy  input  1  write complete.
- busy  output  1  high in any state other than IDLE.
- gnt  output  1  index of the current or last granted port.

Interface (already decided): one clock `clk`; `rst` is asynchronous, active-high.

Behaviour:
- Reset: all outputs 0, state IDLE, priority pointer = port 0. Reset mid-transaction aborts it: no ack is issued and strobes drop immediately.
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - If exactly one req is high, grant that port.
  - If both are high, grant the port with priority.
  - On grant, latch that port's we, addr and wdata into mem_addr/mem_wdata, set gnt, go to ISSUE.
  - With no req, stay in IDLE.
- ISSUE (1 cycle): mem_start = ~we, or mem_w = we. Go to WAIT.
- WAIT:
  - Completion is mem_readrdy for a read or mem_saverdy for a write. The wrong-type rdy is ignored.
  - On completion: latch mem_rdata (reads only; writes return 0) and go to ACK.
  - A rdy already high in the ISSUE cycle counts as completion in the first WAIT cycle.
- ACK (1 cycle):
  - Raise ack of the granted port; the matching rdata is valid.
  - Priority pointer moves to the other port. Go to IDLE.
- Latency: req sampled at edge N gives strobe in cycle N+1. With rdy arriving k cycles after the strobe (k ≥ 1), ack is high in cycle N+k+2.
- Requester rule: deassert req on the edge that ends the ack cycle. IDLE samples req again at the next edge.
- Request timing: req raised during a transaction waits; no requests are lost.
- Data hold: mem_addr and mem_wdata stay constant from ISSUE through ACK and keep their last value in IDLE. rdataN holds its value after ack.
- Starvation bound: a continuously requesting port waits at most one foreign transaction.
- busy = (state != IDLE).

Optional Feature:
- MEM_ARB_TIMEOUT_EN, defined:
  - A counter runs in WAIT.
  - Reaching TIMEOUT cycles without completion forces ACK with rdata = 0 and sets a sticky output `err` (1 bit).
  - `err` clears only on rst.
- Undefined: no counter and no `err` port; WAIT lasts indefinitely.

Test Plan:
- Single read: req0=1, we0=0, addr0=0x0123, mem_readrdy 3 cycles after mem_start with mem_rdata=0xDEADBEEF -> mem_start pulses 1 cycle with mem_addr=0x0123; ack0 1 cycle with rdata0=0xDEADBEEF; ack1 stays 0.
- Write on port 1: req1, we1=1, addr1=0x0800, wdata1=0x12345678, saverdy after 1 cycle -> mem_w pulses once with mem_wdata=0x12345678; ack1 pulses; rdata1=0.
- Simultaneous requests after reset, both held -> order port0, port1, port0, port1; gnt alternates; exactly one strobe per transaction.
- Wrong completion: pending read with mem_saverdy pulsed, then mem_readrdy 5 cycles later -> stays in WAIT through the saverdy; ack only after readrdy.
- Reset during WAIT -> busy, ack and strobes all 0 within the same cycle. After release, a new req0 completes normally with the pointer back at port 0.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT=8, no rdy -> ack0 in cycle N+10 with rdata0=0; err=1 and holds until rst.
